// File: rtl/fc_layer2_if.sv
// rtl/fc_layer2_if.sv - feature, weight and output memory bus of the dense stage
interface fc_layer2_if #(
  parameter int FAW = 12,
  parameter int WAW = 14
);
  logic           frd;
  logic [2:0]     fsel;
  logic [FAW-1:0] faddr;
  logic [19:0]    fdata;
  logic [WAW-1:0] waddr;
  logic [19:0]    wdata;
  logic           owr;
  logic [FAW-1:0] oaddr;
  logic [19:0]    odata;

  modport master (
    output frd, fsel, faddr, waddr, owr, oaddr, odata,
    input  fdata, wdata
  );
  modport slave (
    input  frd, fsel, faddr, waddr, owr, oaddr, odata,
    output fdata, wdata
  );
endinterface

// File: rtl/fc_layer2.sv
// rtl/fc_layer2.sv - dense layer: MAC over pooled map, bias, round, saturate; FC_RELU_EN clamps negatives to 0
module fc_layer2 #(
  parameter int NFEAT = 1024,
  parameter int NOUT  = 10,
  parameter int FAW   = 12,
  parameter int WAW   = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  fc_layer2_if.master bus
);
  localparam int KW = FAW + 1;
  localparam logic [KW-1:0]  KLAST = KW'(NFEAT - 1);
  localparam logic [FAW-1:0] NLAST = FAW'(NOUT - 1);
  localparam logic [WAW-1:0] NSTEP = WAW'(NFEAT + 1);
  localparam logic signed [47:0] SMAX = 48'sh7FFFF;
  localparam logic signed [47:0] SMIN = -48'sh80000;

  typedef enum logic [2:0] {IDLE, CLR, ISSUE, BIAS, DRAIN1, DRAIN2, WRITE, FIN} state_t;
  state_t state, state_nx;

  logic [KW-1:0]  k;
  logic [FAW-1:0] n;
  logic [WAW-1:0] nbase;
  logic           start_block;
  logic           fv, bv, pv;
  logic signed [39:0] mul, prod;
  logic signed [47:0] acc, shr, rnd;
  logic [19:0]    sat, res, ohold;

  // Holds off a start that lands on the same edge reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) start_block <= 1'b1;
    else       start_block <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start && !start_block) state_nx = CLR;
      CLR:    state_nx = ISSUE;
      ISSUE:  if (k == KLAST) state_nx = BIAS;
      BIAS:   state_nx = DRAIN1;
      DRAIN1: state_nx = DRAIN2;
      DRAIN2: state_nx = WRITE;
      WRITE:  state_nx = (n == NLAST) ? FIN : CLR;
      FIN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k     <= '0;
      n     <= '0;
      nbase <= '0;
    end else begin
      if (state == CLR)   k <= '0;
      if (state == ISSUE) k <= k + 1'b1;
      if (state == WRITE && n != NLAST) begin
        n     <= n + 1'b1;
        nbase <= nbase + NSTEP;
      end
      if (state == FIN) begin
        n     <= '0;
        nbase <= '0;
      end
    end
  end

  // Memory data arrives registered one cycle after the address; bias rides the
  // same product slot pre-scaled by 2^16 so the accumulator sees one format.
  assign mul = $signed(bus.fdata) * $signed(bus.wdata);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fv   <= 1'b0;
      bv   <= 1'b0;
      pv   <= 1'b0;
      prod <= '0;
      acc  <= '0;
    end else begin
      fv <= (state == ISSUE);
      bv <= (state == BIAS);
      pv <= fv | bv;
      if (fv)      prod <= mul;
      else if (bv) prod <= {{4{bus.wdata[19]}}, bus.wdata, 16'h0000};
      if (state == CLR) acc <= '0;
      else if (pv)      acc <= acc + {{8{prod[39]}}, prod};
    end
  end

  assign shr = acc >>> 16;
  assign rnd = shr + $signed({47'd0, acc[15]});

  always_comb begin
    sat = rnd[19:0];
    if (rnd > SMAX)      sat = 20'h7FFFF;
    else if (rnd < SMIN) sat = 20'h80000;
  end

`ifdef FC_RELU_EN
  assign res = sat[19] ? 20'h00000 : sat;
`else
  assign res = sat;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               ohold <= '0;
    else if (state == WRITE) ohold <= res;
  end

  assign busy      = (state != IDLE) && (state != FIN);
  assign done      = (state == FIN);
  assign bus.frd   = (state == ISSUE);
  assign bus.fsel  = (state == ISSUE) ? 3'b011 : 3'b000;
  assign bus.faddr = (state == ISSUE) ? k[FAW-1:0] : '0;
  assign bus.waddr = (state == ISSUE) ? nbase + WAW'(k) :
                     (state == BIAS)  ? nbase + WAW'(NFEAT) : '0;
  assign bus.owr   = (state == WRITE);
  assign bus.oaddr = (state == WRITE) ? n : '0;
  assign bus.odata = (state == WRITE) ? res : ohold;
endmodule

// File: tb/tb_fc_layer2.sv
// tb/tb_fc_layer2.sv - scoreboard bench for fc_layer2 with NFEAT=4, NOUT=2
module tb_fc_layer2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  fc_layer2_if #(.FAW(12), .WAW(14)) bus ();

  fc_layer2 #(.NFEAT(4), .NOUT(2), .FAW(12), .WAW(14)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [19:0] fmem [4];
  logic [19:0] wmem [16];

  always @(posedge clk) begin
    bus.fdata <= fmem[bus.faddr[1:0]];
    bus.wdata <= wmem[bus.waddr[3:0]];
  end

  typedef struct {
    logic [11:0] addr;
    logic [19:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_writes = 0;
  logic prev_owr = 1'b0;

  function automatic logic [19:0] rl(input logic [19:0] v);
`ifdef FC_RELU_EN
    return v[19] ? 20'h00000 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops expected writes, checks fsel pairing and single-cycle owr.
  always @(negedge clk) begin
    exp_t e;
    check("fsel_vs_frd", {29'd0, bus.fsel}, bus.frd ? 32'd3 : 32'd0);
    if (bus.owr === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {20'd0, bus.oaddr}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check("oaddr", {20'd0, bus.oaddr}, {20'd0, e.addr});
        check("odata", {12'd0, bus.odata}, {12'd0, e.data});
      end
      if (prev_owr) check("owr_one_cycle", 32'd1, 32'd0);
    end
    prev_owr = bus.owr;
  end

  task automatic set_f(input logic [19:0] a, b, c, d);
    fmem[0] = a; fmem[1] = b; fmem[2] = c; fmem[3] = d;
  endtask

  task automatic set_w(input logic [19:0] w0, b0, w1, b1);
    for (int i = 0; i < 16; i++) wmem[i] = 20'h0;
    for (int i = 0; i < 4; i++) begin
      wmem[i]     = w0;
      wmem[5 + i] = w1;
    end
    wmem[4] = b0;
    wmem[9] = b1;
  endtask

  task automatic job(input logic [19:0] e0, e1, input bit trace, input int restart_at);
    int c;
    int w0;
    bit seen;
    bit busy_ok;
    exp_t e;
    e.addr = 12'd0; e.data = e0; exp_q.push_back(e);
    e.addr = 12'd1; e.data = e1; exp_q.push_back(e);
    w0 = n_writes;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 1; seen = 1'b0; busy_ok = 1'b1;
    while (c <= 40 && !seen) begin
      if (trace && c >= 11 && c <= 14) begin
        check("trace_frd", {31'd0, bus.frd}, 32'd1);
        check("trace_faddr", {20'd0, bus.faddr}, c - 11);
        check("trace_waddr", {18'd0, bus.waddr}, c - 6);
      end
      if (trace && c == 15) begin
        check("bias_frd", {31'd0, bus.frd}, 32'd0);
        check("bias_waddr", {18'd0, bus.waddr}, 32'd9);
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        check("done_cycle", c, 32'd19);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("odata_hold", {12'd0, bus.odata}, {12'd0, e1});
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        start = (c == restart_at);
        @(negedge clk);
        start = 1'b0;
        c++;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    check("busy_held", {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    check("write_count", n_writes - w0, 32'd2);
    check("queue_empty", exp_q.size(), 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) fmem[i] = 20'h0;
    for (int i = 0; i < 16; i++) wmem[i] = 20'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_frd", {31'd0, bus.frd}, 32'd0);
    check("rst_waddr", {18'd0, bus.waddr}, 32'd0);
    check("rst_owr", {31'd0, bus.owr}, 32'd0);
    check("rst_odata", {12'd0, bus.odata}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    set_f(20'h10000, 20'h10000, 20'h10000, 20'h10000);
    set_w(20'h10000, 20'h0, 20'h10000, 20'h0);
    job(20'h40000, 20'h40000, 1'b1, 0);

    set_f(20'h00001, 20'h00001, 20'h00001, 20'h00001);
    set_w(20'h08000, 20'h0, 20'h0, 20'h0);
    wmem[5] = 20'h08000;
    job(20'h00002, 20'h00001, 1'b0, 0);

    set_f(20'h10000, 20'h10000, 20'h10000, 20'h10000);
    set_w(20'hF0000, 20'h08000, 20'h10000, 20'hF8000);
    job(rl(20'hC8000), 20'h38000, 1'b0, 0);

    set_f(20'h70000, 20'h70000, 20'h70000, 20'h70000);
    set_w(20'h70000, 20'h0, 20'h90000, 20'h0);
    job(20'h7FFFF, rl(20'h80000), 1'b0, 0);

    set_f(20'h10000, 20'h10000, 20'h10000, 20'h10000);
    set_w(20'h10000, 20'h0, 20'h10000, 20'h0);
    job(20'h40000, 20'h40000, 1'b0, 5);

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_frd", {31'd0, bus.frd}, 32'd0);
    check("abort_owr", {31'd0, bus.owr}, 32'd0);
    check("abort_odata", {12'd0, bus.odata}, 32'd0);
    @(negedge clk); start = 1'b1;
    @(posedge clk); reset = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_at_release", {31'd0, busy}, 32'd0);

    set_w(20'hF0000, 20'h08000, 20'h10000, 20'hF8000);
    job(rl(20'hC8000), 20'h38000, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
